// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StWrite,
    StDone,
    StErr
  } loader_state_e;

  localparam logic [7:0] DefaultSyncByte = 8'hA5;

  // Sync byte plus two little-endian count bytes.
  localparam int unsigned HeaderLen = 3;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter; expired holds once TIMEOUT-1 idle cycles have elapsed.
module loader_timeout #(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] cnt_q;

  assign expired = (cnt_q == CntW'(TIMEOUT - 1));

  // Saturates at the limit so a stalled FSM can never see the count wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: assembles a UART byte stream into 32-bit words and writes them
// to instruction memory while holding the core in flush/stall.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = DefaultSyncByte,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_write_en,
  output logic [ADDR_W-1:0] imem_write_addr,
  output logic [31:0]       imem_write_data,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  loader_state_e     state_q;
  logic [1:0]        byte_idx_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [ADDR_W-1:0] count_q;
  logic [7:0]        len_lo_q;
  logic [31:0]       word_buf_q;

  logic              rx_ready_q;
  logic              write_en_q;
  logic [ADDR_W-1:0] write_addr_q;
  logic [31:0]       write_data_q;
  logic              core_hold_q;
  logic              load_done_q;
  logic              load_err_q;

  logic              accept;
  logic              is_sync;
  logic              counting;
  logic              expired;
  logic [15:0]       frame_len;
  logic [31:0]       next_word;

  assign accept    = rx_valid && rx_ready_q;
  assign is_sync   = (rx_data == SYNC_BYTE);
  assign counting  = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
  assign frame_len = {rx_data, len_lo_q};
  // Little-endian: the first byte of a word ends up in bits [7:0].
  assign next_word = {rx_data, word_buf_q[31:8]};

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept || !counting),
    .enable  (counting),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      byte_idx_q   <= '0;
      word_idx_q   <= '0;
      count_q      <= '0;
      len_lo_q     <= '0;
      word_buf_q   <= '0;
      rx_ready_q   <= 1'b1;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      core_hold_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      write_en_q  <= 1'b0;
      load_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept && is_sync) begin
            state_q     <= StLenLo;
            core_hold_q <= 1'b1;
          end
        end
        StLenLo: begin
          if (accept) begin
            len_lo_q <= rx_data;
            state_q  <= StLenHi;
          end else if (expired) begin
            state_q    <= StErr;
            load_err_q <= 1'b1;
          end
        end
        StLenHi: begin
          if (accept) begin
            count_q <= ADDR_W'(frame_len);
            if (frame_len == 16'd0) begin
              state_q     <= StDone;
              load_done_q <= 1'b1;
            end else begin
              state_q    <= StData;
              word_idx_q <= '0;
              byte_idx_q <= '0;
            end
          end else if (expired) begin
            state_q    <= StErr;
            load_err_q <= 1'b1;
          end
        end
        StData: begin
          if (accept) begin
            word_buf_q <= next_word;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              state_q      <= StWrite;
              rx_ready_q   <= 1'b0;
              write_en_q   <= 1'b1;
              write_addr_q <= word_idx_q;
              write_data_q <= next_word;
            end
          end else if (expired) begin
            state_q    <= StErr;
            load_err_q <= 1'b1;
            word_buf_q <= '0;
            byte_idx_q <= '0;
          end
        end
        StWrite: begin
          rx_ready_q <= 1'b1;
          word_idx_q <= word_idx_q + ADDR_W'(1);
          if (word_idx_q == count_q - ADDR_W'(1)) begin
            state_q     <= StDone;
            load_done_q <= 1'b1;
          end else begin
            state_q <= StData;
          end
        end
        StDone: begin
          state_q     <= StIdle;
          core_hold_q <= 1'b0;
        end
        StErr: begin
          if (accept && is_sync) begin
            state_q    <= StLenLo;
            load_err_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          core_hold_q <= 1'b0;
          rx_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign rx_ready        = rx_ready_q;
  assign imem_write_en   = write_en_q;
  assign imem_write_addr = write_addr_q;
  assign imem_write_data = write_data_q;
  assign core_hold       = core_hold_q;
  assign load_done       = load_done_q;
  assign load_err        = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, discard, timeout, stall and reset.
module tb_imem_loader;

  localparam int unsigned AddrW   = 16;
  localparam int unsigned Timeout = 16;

  logic             clk;
  logic             rst;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             imem_write_en;
  logic [AddrW-1:0] imem_write_addr;
  logic [31:0]      imem_write_data;
  logic             core_hold;
  logic             load_done;
  logic             load_err;

  imem_loader #(
    .SYNC_BYTE (8'hA5),
    .ADDR_W    (AddrW),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_ready        (rx_ready),
    .imem_write_en   (imem_write_en),
    .imem_write_addr (imem_write_addr),
    .imem_write_data (imem_write_data),
    .core_hold       (core_hold),
    .load_done       (load_done),
    .load_err        (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Write/pulse monitor, sampled mid-cycle.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cnt    = 0;
  int          hold_cycles = 0;
  int          ready_viol  = 0;
  bit          armed       = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      if (imem_write_en === 1'b1) begin
        wr_addr.push_back(32'(imem_write_addr));
        wr_data.push_back(imem_write_data);
      end
      if (load_done === 1'b1) done_cnt++;
      if (core_hold === 1'b1) hold_cycles++;
      if (rx_ready !== !imem_write_en) ready_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    done_cnt    = 0;
    hold_cycles = 0;
    ready_viol  = 0;
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    bit seen;
    seen     = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 8; i++) begin
      if (rx_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL rx_ready_timeout: observed 0 expected 1 for byte %0h", b);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({pfx, "_we"}, 32'(imem_write_en), 32'd0);
    check({pfx, "_waddr"}, 32'(imem_write_addr), 32'd0);
    check({pfx, "_wdata"}, imem_write_data, 32'd0);
    check({pfx, "_hold"}, 32'(core_hold), 32'd0);
    check({pfx, "_done"}, 32'(load_done), 32'd0);
    check({pfx, "_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst   = 1'b0;
    armed = 1'b1;
    @(negedge clk);

    // Two-word load.
    clear_mon();
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88});
    repeat (4) @(negedge clk);
    check("f1_nwr", 32'(wr_addr.size()), 32'd2);
    check("f1_a0", wr_addr[0], 32'd0);
    check("f1_d0", wr_data[0], 32'h44332211);
    check("f1_a1", wr_addr[1], 32'd1);
    check("f1_d1", wr_data[1], 32'h88776655);
    check("f1_done", 32'(done_cnt), 32'd1);
    check("f1_hold_span", 32'(hold_cycles), 32'd13);
    check("f1_hold_after", 32'(core_hold), 32'd0);

    // Noise then an empty frame.
    clear_mon();
    send_frame('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00});
    repeat (4) @(negedge clk);
    check("f2_nwr", 32'(wr_addr.size()), 32'd0);
    check("f2_done", 32'(done_cnt), 32'd1);
    check("f2_hold_span", 32'(hold_cycles), 32'd3);

    // Stall mid-word, then recover with a fresh frame.
    clear_mon();
    send_frame('{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB});
    repeat (Timeout - 1) @(negedge clk);
    check("to_err_early", 32'(load_err), 32'd0);
    @(negedge clk);
    check("to_err", 32'(load_err), 32'd1);
    check("to_hold", 32'(core_hold), 32'd1);
    check("to_ready", 32'(rx_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("to_nwr", 32'(wr_addr.size()), 32'd0);
    check("to_done", 32'(done_cnt), 32'd0);
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
    repeat (4) @(negedge clk);
    check("rec_nwr", 32'(wr_addr.size()), 32'd1);
    check("rec_a0", wr_addr[0], 32'd0);
    check("rec_d0", wr_data[0], 32'h04030201);
    check("rec_err", 32'(load_err), 32'd0);
    check("rec_hold", 32'(core_hold), 32'd0);

    // Back-to-back bytes across WRITE bubbles.
    clear_mon();
    send_frame('{8'hA5, 8'h03, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B});
    repeat (4) @(negedge clk);
    check("bb_nwr", 32'(wr_addr.size()), 32'd3);
    check("bb_a0", wr_addr[0], 32'd0);
    check("bb_d0", wr_data[0], 32'h13121110);
    check("bb_a1", wr_addr[1], 32'd1);
    check("bb_d1", wr_data[1], 32'h17161514);
    check("bb_a2", wr_addr[2], 32'd2);
    check("bb_d2", wr_data[2], 32'h1B1A1918);
    check("bb_ready_vs_we", 32'(ready_viol), 32'd0);
    check("bb_hold_span", 32'(hold_cycles), 32'd18);

    // Reset after two of four words.
    clear_mon();
    send_frame('{8'hA5, 8'h04, 8'h00, 8'hC0, 8'hC1, 8'hC2, 8'hC3,
                 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9});
    check("mr_nwr", 32'(wr_addr.size()), 32'd2);
    check("mr_hold_pre", 32'(core_hold), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mr");
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
    send_frame('{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
    repeat (4) @(negedge clk);
    check("mr2_nwr", 32'(wr_addr.size()), 32'd1);
    check("mr2_a0", wr_addr[0], 32'd0);
    check("mr2_d0", wr_data[0], 32'hEFBEADDE);

    // Sync value inside the data field.
    clear_mon();
    send_frame('{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5});
    repeat (4) @(negedge clk);
    check("sd_nwr", 32'(wr_addr.size()), 32'd1);
    check("sd_a0", wr_addr[0], 32'd0);
    check("sd_d0", wr_data[0], 32'hA5A5A5A5);
    check("sd_done", 32'(done_cnt), 32'd1);
    check("sd_hold", 32'(core_hold), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the fetch-stage instruction memory. Receives a byte stream from a UART receiver over a valid/ready handshake, assembles little-endian 32-bit words, and drives the memory write port (`write_en`/`write_addr`/`write_data`). While a load is in progress it holds the core: its hold output drives the fetch stage's flush and deasserts the memory read enable. On completion it releases the core to fetch from address 0.

## Interface
- `SYNC_BYTE`, 8'hA5: byte that starts a load.
- `ADDR_W`, 16: memory word-address width; also the width of the word count.
- `TIMEOUT`, 1_000_000: maximum idle cycles between bytes during a load; must be ≥ 2.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_valid`  in  1  byte available.
- `rx_data`  in  8  byte value.
- `rx_ready`  out  1  loader accepts the byte this cycle.
- `imem_write_en`  out  1  one-cycle write strobe.
- `imem_write_addr`  out  ADDR_W  word address.
- `imem_write_data`  out  32  assembled word.
- `core_hold`  out  1  core held (flush and fetch stall).
- `load_done`  out  1  one-cycle pulse when a load completes.
- `load_err`  out  1  sticky timeout flag.

## Operation
- A byte is accepted when `rx_valid && rx_ready`.
- Frame format: SYNC_BYTE, count low byte, count high byte, then count×4 data bytes. Count and words are little-endian; the first data byte lands in bits [7:0].
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- IDLE:
  - `rx_ready`=1.
  - A non-sync byte is discarded.
  - SYNC_BYTE → LEN_LO, and `core_hold` rises.
- LEN_LO: accept byte → LEN_HI.
- LEN_HI: accept byte, then:
  - count = 0 → DONE;
  - otherwise → DATA, with word index = 0 and byte index = 0.
- DATA:
  - `rx_ready`=1; each accepted byte shifts into the word buffer.
  - On the 4th byte → WRITE.
- WRITE:
  - `rx_ready`=0.
  - `imem_write_en`=1, `imem_write_addr`=word index, `imem_write_data`=buffer.
  - Word index increments.
  - If the written word was word count−1 → DONE; otherwise → DATA.
- DONE:
  - `load_done`=1 for this one cycle.
  - `core_hold` stays 1 this cycle, then → IDLE with `core_hold`=0.
- Timeout counter:
  - Clears on every accepted byte and on entry to LEN_LO.
  - Increments each cycle in LEN_LO, LEN_HI and DATA.
  - When it reaches TIMEOUT−1 with no byte accepted → ERR.
- ERR:
  - `load_err`=1; `core_hold` remains 1; the partial word is discarded; `rx_ready`=1.
  - SYNC_BYTE → LEN_LO and clears `load_err`; other bytes are discarded.
- Word index is ADDR_W bits wide. The maximum count (2^ADDR_W−1) never wraps.
- SYNC_BYTE appearing inside a count or data field is treated as data, not a restart.

## Timing
- All outputs are registered.
- Reset values: `rx_ready`=1, `imem_write_en`=0, `imem_write_addr`=0, `imem_write_data`=0, `core_hold`=0, `load_done`=0, `load_err`=0.
- Reset mid-load aborts immediately to IDLE. Written words stay in memory; the partial word is lost; `core_hold` drops the cycle after `rst`.
- `core_hold` is 1 from the cycle after the SYNC_BYTE is accepted through the DONE cycle inclusive.
- Write latency: `imem_write_en` is high exactly one cycle after the 4th byte of a word is accepted.
- Throughput: at most one byte per cycle, plus one WRITE bubble per word, so a frame takes ≥ 3 + 5·count + 1 cycles.
- A timeout and a byte arriving in the same cycle: the byte wins and the counter clears.
- `rx_valid` with `rx_ready`=0 (WRITE state): the byte is not consumed; the source must hold it.

## Structure
- Shared package `loader_pkg`: FSM state enum, SYNC_BYTE default, frame-header length constant.
- Sub-module `loader_timeout`: counter with clear/enable inputs and an expired output, parameterised by TIMEOUT.
- Top level contains the FSM, byte index (2 bits), word index, word-count register and 32-bit shift buffer.
- Integration: `core_hold` ORs into the fetch flush and gates the memory read enable.

## Test plan
- Reset, then stream A5 02 00 | 11 22 33 44 | 55 66 77 88 → writes addr 0 = 0x44332211 and addr 1 = 0x88776655, one `load_done` pulse, `core_hold` 0 afterwards.
- Stream 00 FF A5 00 00 → the first two bytes are discarded, there is no write, `load_done` pulses, `core_hold` is high for exactly the LEN_LO–DONE span.
- Stream A5 01 00 AA BB, then silence for TIMEOUT cycles → ERR, `load_err`=1, `core_hold`=1, no write. Then A5 01 00 01 02 03 04 → addr 0 = 0x04030201 and `load_err` cleared.
- Hold `rx_valid` high continuously during a 3-word load → `rx_ready`=0 exactly in each WRITE cycle, no byte lost, addresses 0, 1, 2 in order.
- Assert `rst` after 2 of 4 words are written → outputs return to reset values next cycle. A fresh frame then loads correctly from addr 0.
- Data byte equal to A5 inside a word (A5 01 00 A5 A5 A5 A5) → addr 0 = 0xA5A5A5A5, no restart.
